// File: rtl/leve_alu_sched.sv
// Two-requester scheduler for a shared fixed-latency ALU with result routing, flush and error flag.
// Optional round-robin arbitration is enabled with `define ALU_SCHED_RR_EN (fixed priority otherwise).

`ifndef XLEN
`define XLEN 32
`endif

module leve_alu_sched #(
    parameter int unsigned XLEN    = `XLEN,
    parameter int unsigned RIDW    = 5,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  logic [2*XLEN-1:0]   req_rs1_i,
    input  logic [2*XLEN-1:0]   req_rs2_i,
    input  logic [2*RIDW-1:0]   req_rd_i,
    output logic                alu_valid_o,
    output logic [XLEN-1:0]     alu_rs1_o,
    output logic [XLEN-1:0]     alu_rs2_o,
    input  logic                alu_rd_we_i,
    input  logic [XLEN-1:0]     alu_rd_d_i,
    output logic [1:0]          rsp_valid_o,
    output logic [RIDW-1:0]     rsp_rd_o,
    output logic [XLEN-1:0]     rsp_d_o,
    input  logic                kill_i,
    output logic                busy_o,
    output logic                err_o
);

    localparam int unsigned Tail = ALU_LAT - 1;

    logic [1:0]         gnt;
    logic               gnt_idx;
    logic [ALU_LAT-1:0] v_q, v_d;
    logic [ALU_LAT-1:0] own_q, own_d;
    logic [RIDW-1:0]    rd_q [ALU_LAT];
    logic [RIDW-1:0]    rd_d [ALU_LAT];
    logic [2:0]         drop_q, drop_d;
    logic               err_q, err_d;
    logic               tail_v;
    logic               rsp_fire;

`ifdef ALU_SCHED_RR_EN
    logic last_q, last_d;
`endif

    always_comb begin
        gnt = 2'b00;
        if (!rst_i && !kill_i) begin
`ifdef ALU_SCHED_RR_EN
            if (req_valid_i == 2'b11) begin
                gnt = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req_valid_i;
            end
`else
            if (req_valid_i[0]) begin
                gnt = 2'b01;
            end else if (req_valid_i[1]) begin
                gnt = 2'b10;
            end
`endif
        end
    end

    assign gnt_idx     = gnt[1];
    assign req_ready_o = gnt;
    assign alu_valid_o = |gnt;
    assign alu_rs1_o   = gnt_idx ? req_rs1_i[2*XLEN-1:XLEN] : req_rs1_i[XLEN-1:0];
    assign alu_rs2_o   = gnt_idx ? req_rs2_i[2*XLEN-1:XLEN] : req_rs2_i[XLEN-1:0];

`ifdef ALU_SCHED_RR_EN
    assign last_d = (|gnt) ? gnt_idx : last_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Tag pipe: stage 0 takes this cycle's issue, the tail lines up with the ALU result.
    always_comb begin
        v_d      = '0;
        own_d    = '0;
        v_d[0]   = |gnt;
        own_d[0] = gnt_idx;
        rd_d[0]  = gnt_idx ? req_rd_i[2*RIDW-1:RIDW] : req_rd_i[RIDW-1:0];
        for (int i = 1; i < int'(ALU_LAT); i++) begin
            v_d[i]   = v_q[i-1];
            own_d[i] = own_q[i-1];
            rd_d[i]  = rd_q[i-1];
        end
        if (kill_i) begin
            v_d = '0;
        end
    end

    assign tail_v   = v_q[Tail];
    assign rsp_fire = tail_v && alu_rd_we_i && !kill_i && !rst_i;

    assign rsp_valid_o = rsp_fire ? (own_q[Tail] ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rd_o    = rd_q[Tail];
    assign rsp_d_o     = alu_rd_d_i;

    // Results of killed ops still arrive for ALU_LAT cycles; the drop window swallows them.
    always_comb begin
        drop_d = drop_q;
        if (kill_i) begin
            drop_d = 3'(ALU_LAT);
        end else if (drop_q != 3'd0) begin
            drop_d = drop_q - 3'd1;
        end
    end

    always_comb begin
        err_d = err_q;
        if (!kill_i && ((alu_rd_we_i && !tail_v && drop_q == 3'd0) ||
                        (tail_v && !alu_rd_we_i))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q    <= '0;
            drop_q <= 3'd0;
            err_q  <= 1'b0;
        end else begin
            v_q    <= v_d;
            drop_q <= drop_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        own_q <= own_d;
        rd_q  <= rd_d;
    end

    assign busy_o = !rst_i && (|v_q);
    assign err_o  = err_q;

endmodule

// File: tb/tb_leve_alu_sched.sv
// Randomized self-checking bench for leve_alu_sched; the reference tracks ops by issue cycle.
// The bench acts as the ALU, returning rs1+rs2 exactly ALU_LAT cycles after each issue.

module tb_leve_alu_sched;

    localparam int XW  = 16;
    localparam int RW  = 5;
    localparam int LAT = 3;
    localparam int N   = 2048;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [2*XW-1:0] req_rs1 = '0;
    logic [2*XW-1:0] req_rs2 = '0;
    logic [2*RW-1:0] req_rd = '0;
    logic            alu_valid;
    logic [XW-1:0]   alu_rs1;
    logic [XW-1:0]   alu_rs2;
    logic            alu_rd_we = 1'b0;
    logic [XW-1:0]   alu_rd_d = '0;
    logic [1:0]      rsp_valid;
    logic [RW-1:0]   rsp_rd;
    logic [XW-1:0]   rsp_d;
    logic            kill = 1'b0;
    logic            busy;
    logic            err;

    always #5 clk = ~clk;

    leve_alu_sched #(
        .XLEN   (XW),
        .RIDW   (RW),
        .ALU_LAT(LAT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_rs1_i  (req_rs1),
        .req_rs2_i  (req_rs2),
        .req_rd_i   (req_rd),
        .alu_valid_o(alu_valid),
        .alu_rs1_o  (alu_rs1),
        .alu_rs2_o  (alu_rs2),
        .alu_rd_we_i(alu_rd_we),
        .alu_rd_d_i (alu_rd_d),
        .rsp_valid_o(rsp_valid),
        .rsp_rd_o   (rsp_rd),
        .rsp_d_o    (rsp_d),
        .kill_i     (kill),
        .busy_o     (busy),
        .err_o      (err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state, indexed by cycle number.
    bit            iss_v   [N];
    bit            iss_own [N];
    logic [RW-1:0] iss_rd  [N];
    bit            alive   [N];
    bit            sch_we  [N];
    logic [XW-1:0] sch_d   [N];
    int            t        = 0;
    bit            err_m    = 1'b0;
    int            drop_end = -1;
    int            last_m   = 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    // we_mode: 0 = natural ALU behaviour, 1 = force a write pulse, 2 = suppress the write pulse
    task automatic do_cycle(input bit r, input bit k, input bit [1:0] v, input int we_mode);
        logic [XW-1:0] a0, a1, b0, b1, wd;
        logic [RW-1:0] d0, d1;
        bit            we, tail, busy_e;
        bit [1:0]      g, rsp_e;
        int            ti;
        @(posedge clk);
        #1;
        a0 = XW'($urandom); a1 = XW'($urandom);
        b0 = XW'($urandom); b1 = XW'($urandom);
        d0 = RW'($urandom); d1 = RW'($urandom);
        we = (we_mode == 0) ? sch_we[t] : (we_mode == 1);
        wd = sch_we[t] ? sch_d[t] : XW'($urandom);
        rst       = r;
        kill      = k;
        req_valid = v;
        req_rs1   = {a1, a0};
        req_rs2   = {b1, b0};
        req_rd    = {d1, d0};
        alu_rd_we = we;
        alu_rd_d  = wd;
        #3;
        g = 2'b00;
        if (!r && !k) begin
`ifdef ALU_SCHED_RR_EN
            if (v == 2'b11) g = (last_m == 0) ? 2'b10 : 2'b01;
            else g = v;
`else
            if (v[0]) g = 2'b01;
            else if (v[1]) g = 2'b10;
`endif
        end
        ti    = t - LAT;
        tail  = (ti >= 0) && iss_v[ti] && alive[ti];
        rsp_e = (tail && we && !k && !r) ? (iss_own[ti] ? 2'b10 : 2'b01) : 2'b00;
        busy_e = 1'b0;
        if (!r) begin
            for (int j = t - LAT; j < t; j++) begin
                if (j >= 0 && iss_v[j] && alive[j]) busy_e = 1'b1;
            end
        end
        check_eq("req_ready", 64'(req_ready), 64'(g));
        check_eq("alu_valid", 64'(alu_valid), 64'(|g));
        check_eq("rsp_valid", 64'(rsp_valid), 64'(rsp_e));
        check_eq("busy", 64'(busy), 64'(busy_e));
        check_eq("err", 64'(err), 64'(err_m));
        if (g != 2'b00) begin
            check_eq("alu_rs1", 64'(alu_rs1), 64'(g[1] ? a1 : a0));
            check_eq("alu_rs2", 64'(alu_rs2), 64'(g[1] ? b1 : b0));
        end
        if (rsp_e != 2'b00) begin
            check_eq("rsp_d", 64'(rsp_d), 64'(sch_d[t]));
            check_eq("rsp_rd", 64'(rsp_rd), 64'(iss_rd[ti]));
        end
        // Advance the reference to the end of this cycle.
        if (r) begin
            err_m    = 1'b0;
            drop_end = -1;
            last_m   = 1;
        end else begin
            if (!k && ((we && !tail && t > drop_end) || (tail && !we))) err_m = 1'b1;
            if (k) drop_end = t + LAT;
            if (g != 2'b00) last_m = int'(g[1]);
        end
        if (g != 2'b00) begin
            iss_v[t]       = 1'b1;
            iss_own[t]     = g[1];
            iss_rd[t]      = g[1] ? d1 : d0;
            alive[t]       = 1'b1;
            sch_we[t+LAT]  = 1'b1;
            sch_d[t+LAT]   = g[1] ? a1 + b1 : a0 + b0;
        end
        if (r || k) begin
            for (int j = t - LAT + 1; j < t; j++) begin
                if (j >= 0) alive[j] = 1'b0;
            end
        end
        // The ALU is reset along with the scheduler, so its pending results vanish.
        if (r) begin
            for (int j = t + 1; j <= t + LAT; j++) sch_we[j] = 1'b0;
        end
        t++;
    endtask

    initial begin
        do_cycle(1, 0, 2'b00, 0);
        do_cycle(1, 0, 2'b11, 0);
        // single op and its return
        do_cycle(0, 0, 2'b01, 0);
        repeat (LAT + 1) do_cycle(0, 0, 2'b00, 0);
        // contention held for 4 cycles
        repeat (4) do_cycle(0, 0, 2'b11, 0);
        repeat (LAT + 1) do_cycle(0, 0, 2'b00, 0);
        // random traffic with occasional flushes
        repeat (300) do_cycle(0, ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)), 0);
        // flush with a full pipe
        repeat (LAT) do_cycle(0, 0, 2'b11, 0);
        do_cycle(0, 1, 2'b11, 0);
        repeat (LAT + 1) do_cycle(0, 0, 2'b00, 0);
        // spurious ALU result on an empty pipe, error must stick
        do_cycle(0, 0, 2'b00, 1);
        repeat (3) do_cycle(0, 0, 2'b00, 0);
        do_cycle(1, 0, 2'b00, 0);
        // reset mid-stream, first grant afterwards goes to requester 0
        repeat (2) do_cycle(0, 0, 2'b11, 0);
        do_cycle(1, 0, 2'b11, 0);
        do_cycle(0, 0, 2'b11, 0);
        repeat (LAT + 1) do_cycle(0, 0, 2'b00, 0);
        // missing ALU result for a valid tail entry
        do_cycle(0, 0, 2'b10, 0);
        repeat (LAT - 1) do_cycle(0, 0, 2'b00, 0);
        do_cycle(0, 0, 2'b00, 2);
        repeat (2) do_cycle(0, 0, 2'b01, 0);
        do_cycle(1, 0, 2'b00, 0);
        // random traffic with flushes and resets
        repeat (300) do_cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 14) == 0),
                              2'($urandom_range(0, 3)), 0);
        repeat (LAT + 1) do_cycle(0, 0, 2'b00, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/leve_alu_sched.md
LEVE_ALU_SCHED -- requirements
Module: LEVE_ALU_SCHED

Interface
REQ-001 SHALL take parameter XLEN, default `XLEN, operand/result width.
REQ-002 SHALL take parameter RIDW, default 5, destination register index width.
REQ-003 SHALL take parameter ALU_LAT, default 1, ALU issue-to-result latency in cycles; legal range 1..4.
REQ-004 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-005 SHALL have port RST  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port REQ_VALID  in  2  bit i = requester i has an operation.
REQ-007 SHALL have port REQ_READY  out  2  bit i = requester i granted this cycle.
REQ-008 SHALL have port REQ_RS1  in  2*XLEN  packed operand 1; slice i belongs to requester i.
REQ-009 SHALL have port REQ_RS2  in  2*XLEN  packed operand 2; slice i belongs to requester i.
REQ-010 SHALL have port REQ_RD  in  2*RIDW  packed destination index; slice i belongs to requester i.
REQ-011 SHALL have port ALU_VALID  out  1  issue strobe to the ALU (RS_D_VALID side).
REQ-012 SHALL have ports ALU_RS1 and ALU_RS2  out  XLEN each  muxed operands to the ALU.
REQ-013 SHALL have port ALU_RD_WE  in  1  ALU result valid.
REQ-014 SHALL have port ALU_RD_D  in  XLEN  ALU result.
REQ-015 SHALL have port RSP_VALID  out  2  one-hot; bit i = result returned to requester i.
REQ-016 SHALL have port RSP_RD  out  RIDW  destination index of the returned result.
REQ-017 SHALL have port RSP_D  out  XLEN  returned result data.
REQ-018 SHALL have port KILL  in  1  flush: drop all in-flight operations.
REQ-019 SHALL have port BUSY  out  1  one or more operations in flight.
REQ-020 SHALL have port ERR  out  1  sticky protocol error.

Function
REQ-021 Handshake: a transfer occurs when REQ_VALID[i] & REQ_READY[i]; at most one REQ_READY bit is high per cycle.
REQ-022 REQ_READY is combinational from REQ_VALID, the arbitration state and KILL. No grant is issued while KILL=1 or RST=1.
REQ-023 Issue: ALU_VALID = |(REQ_VALID & REQ_READY). ALU_RS1 and ALU_RS2 are driven combinationally from the granted slice; when no grant, their value is don't-care.
REQ-024 Tag pipe: an ALU_LAT-deep shift register of {valid, owner, rd}. Each issue pushes {1, i, REQ_RD[i]}; non-issue cycles push valid=0. The pipe advances every cycle.
REQ-025 Return: when the tail entry is valid and ALU_RD_WE=1, the block SHALL assert RSP_VALID[owner] in the same cycle, with RSP_D=ALU_RD_D and RSP_RD=tail rd. Responses have no backpressure.
REQ-026 Full throughput: back-to-back issue every cycle is allowed; ALU_LAT operations may be in flight.
REQ-027 BUSY SHALL be 1 while any tag-pipe entry is valid.
REQ-028 ERR SHALL set on ALU_RD_WE=1 with an invalid tail entry, or on a valid tail entry with ALU_RD_WE=0. ERR clears only on RST. The offending cycle produces no RSP_VALID.
REQ-029 KILL SHALL clear all tag valid bits at the clock edge. RSP_VALID is forced to 0 during the KILL cycle. ALU_RD_WE pulses from killed operations are ignored and SHALL NOT set ERR; a drop counter covers the ALU_LAT cycles after KILL.
REQ-030 Simultaneous issue and return in one cycle are independent and both occur.

Reset
REQ-031 On RST: tag pipe valid bits=0, drop counter=0, ERR=0, arbitration pointer LAST=1 (requester 0 wins first).
REQ-032 While RST=1: REQ_READY=0, ALU_VALID=0, RSP_VALID=0, BUSY=0. A reset asserted mid-operation discards all in-flight operations silently.

Configuration
REQ-033 With ALU_SCHED_RR_EN defined: round-robin arbitration. On contention, grant the requester not equal to LAST; LAST updates on every grant.
REQ-034 Without ALU_SCHED_RR_EN: fixed priority, requester 0 always wins; LAST is not implemented.

Verification
REQ-035 Single op: REQ_VALID=01, RS1=3, RS2=4, RD=7, ALU_LAT=1 -> READY=01 and ALU_VALID in cycle 0; cycle 1: RSP_VALID=01, RSP_D=7, RSP_RD=7.
REQ-036 Contention with RR_EN: REQ_VALID=11 held for 4 cycles after reset -> grants 0,1,0,1; responses routed to the matching owners in order.
REQ-037 Contention without RR_EN: REQ_VALID=11 held for 3 cycles -> grants 0,0,0; REQ_READY[1] stays 0.
REQ-038 KILL with ALU_LAT=3 and 3 ops in flight -> no RSP_VALID for the following 3 cycles, BUSY=0 after the edge, ERR stays 0.
REQ-039 Spurious ALU_RD_WE=1 with an empty pipe, no KILL pending -> ERR=1 and held until RST; RSP_VALID=00.
REQ-040 RST asserted mid-stream with 2 ops in flight -> next cycle all outputs at reset values; the first grant after reset goes to requester 0.
